// File: rtl/shift_sequencer_dlx_if.sv
// rtl/shift_sequencer_dlx_if.sv - start/busy/done handshake and operand bus for the sequential shifter
interface shift_sequencer_dlx_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   DI;
  logic [SHAMT_W-1:0] amount;
  logic               right;
  logic               arith;
  logic [WIDTH-1:0]   DO;
  logic               busy;
  logic               done;

  modport master (
    output start, DI, amount, right, arith,
    input  DO, busy, done
  );

  modport slave (
    input  start, DI, amount, right, arith,
    output DO, busy, done
  );
endinterface

// File: rtl/shift_sequencer_dlx.sv
// rtl/shift_sequencer_dlx.sv - multi-cycle SLL/SRL/SRA unit, one bit position per clock
module shift_sequencer_dlx #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  shift_sequencer_dlx_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_right;
  logic               r_arith;
  logic [WIDTH-1:0]   r_do;
  logic               r_busy;
  logic               r_done;
  logic               w_fill;
  logic [WIDTH-1:0]   w_step;

  // Fill bit is the sign only for arithmetic right shifts; left shifts always feed zero.
  always_comb begin
    w_fill = r_right & r_arith & r_do[WIDTH-1];
    w_step = r_right ? {w_fill, r_do[WIDTH-1:1]} : {r_do[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_right <= 1'b0;
      r_arith <= 1'b0;
      r_do    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_do    <= bus.DI;
            r_cnt   <= bus.amount;
            r_right <= bus.right;
            r_arith <= bus.arith;
            if (bus.amount == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_do <= w_step;
          // Count of 1 means this edge performs the last step.
          if (r_cnt <= SHAMT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - SHAMT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DO   = r_do;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
